// File: rtl/uop_ibuffer_if.sv
// Valid/ready channel carrying one instruction tagged with its issue warp.
interface uop_ibuffer_if #(
  parameter int WIS_W = 2,
  parameter int DATAW = 128
);
  logic             valid;
  logic [WIS_W-1:0] wis;
  logic [DATAW-1:0] data;
  logic             ready;

  modport master (output valid, output wis, output data, input ready);
  modport slave  (input valid, input wis, input data, output ready);
endinterface

// File: rtl/uop_ibuffer.sv
// Per-warp instruction buffer: one FIFO per issue warp, round-robin selection
// of an eligible head, and a registered output stage towards the scheduler.

module uop_ibuffer_checker #(
  parameter int ISSUE_WARPS = 4,
  parameter int DEPTH       = 4,
  parameter int DATAW       = 128,
  parameter int CW          = 3
) (
  input logic                      clk,
  input logic                      reset,
  input logic [ISSUE_WARPS-1:0]    push,
  input logic [ISSUE_WARPS-1:0]    pop,
  input logic [ISSUE_WARPS*CW-1:0] wcount,
  input logic                      out_valid,
  input logic                      out_ready,
  input logic [DATAW-1:0]          out_data
);
  for (genvar w = 0; w < ISSUE_WARPS; w++) begin : g_warp
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
      push[w] |-> (wcount[w*CW +: CW] != CW'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
      pop[w] |-> (wcount[w*CW +: CW] != CW'(0)));
  end

  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> $stable(out_data));
endmodule

module uop_ibuffer #(
  parameter int ISSUE_WARPS = 4,
  parameter int DEPTH       = 4,
  parameter int DATAW       = 128,
  parameter int WIS_W       = $clog2(ISSUE_WARPS)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  uop_ibuffer_if.slave                             in_if,
  uop_ibuffer_if.master                            out_if,
  input  logic                                     flush_valid,
  input  logic [WIS_W-1:0]                         flush_wis,
  input  logic [ISSUE_WARPS-1:0]                   stall_mask,
  output logic [ISSUE_WARPS*($clog2(DEPTH)+1)-1:0] wcount
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATAW-1:0]       mem_r    [ISSUE_WARPS][DEPTH];
  logic [PW-1:0]          rd_ptr_r [ISSUE_WARPS];
  logic [PW-1:0]          wr_ptr_r [ISSUE_WARPS];
  logic [CW-1:0]          cnt_r    [ISSUE_WARPS];
  logic [WIS_W-1:0]       rr_ptr_r;
  logic                   out_valid_r;
  logic [WIS_W-1:0]       out_wis_r;
  logic [DATAW-1:0]       out_data_r;

  logic                   in_ready_s;
  logic                   in_fire_s;
  logic                   load_en_s;
  logic                   grant_s;
  logic [WIS_W-1:0]       gidx_s;
  logic [DATAW-1:0]       head_s;
  logic [ISSUE_WARPS-1:0] elig_s;
  logic [ISSUE_WARPS-1:0] push_s;
  logic [ISSUE_WARPS-1:0] pop_s;

  // Accept decision; deliberately blind to any pop happening this cycle
  always_comb begin
    in_ready_s = 1'b0;
    if (flush_valid && (flush_wis == in_if.wis)) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = (cnt_r[in_if.wis] < CW'(DEPTH));
    end
  end

  assign in_fire_s   = in_if.valid && in_ready_s;
  assign in_if.ready = in_ready_s;
  assign load_en_s   = !out_valid_r || out_if.ready;

  // Per-warp eligibility and push decode
  always_comb begin
    elig_s = {ISSUE_WARPS{1'b0}};
    push_s = {ISSUE_WARPS{1'b0}};
    for (int w = 0; w < ISSUE_WARPS; w++) begin
      elig_s[w] = (cnt_r[w] != CW'(0)) && !stall_mask[w] &&
                  !(flush_valid && (flush_wis == WIS_W'(w)));
      push_s[w] = in_fire_s && (in_if.wis == WIS_W'(w));
    end
  end

  // Round-robin search starting at rr_ptr; index arithmetic wraps naturally
  always_comb begin
    logic             found;
    logic [WIS_W-1:0] cand;
    found  = 1'b0;
    cand   = rr_ptr_r;
    gidx_s = rr_ptr_r;
    pop_s  = {ISSUE_WARPS{1'b0}};
    for (int i = 0; i < ISSUE_WARPS; i++) begin
      cand   = rr_ptr_r + WIS_W'(i);
      gidx_s = (!found && elig_s[cand]) ? cand : gidx_s;
      found  = found || elig_s[cand];
    end
    grant_s = found && load_en_s;
    for (int w = 0; w < ISSUE_WARPS; w++) begin
      pop_s[w] = grant_s && (gidx_s == WIS_W'(w));
    end
  end

  assign head_s = mem_r[gidx_s][rd_ptr_r[gidx_s]];

  // Payload storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      mem_r[in_if.wis][wr_ptr_r[in_if.wis]] <= in_if.data;
    end
  end

  // Pointer and occupancy bookkeeping; a flush overrides everything for its warp
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < ISSUE_WARPS; w++) begin
        rd_ptr_r[w] <= PW'(0);
        wr_ptr_r[w] <= PW'(0);
        cnt_r[w]    <= CW'(0);
      end
    end else begin
      for (int w = 0; w < ISSUE_WARPS; w++) begin
        if (flush_valid && (flush_wis == WIS_W'(w))) begin
          cnt_r[w]    <= CW'(0);
          rd_ptr_r[w] <= wr_ptr_r[w];
        end else begin
          if (push_s[w]) wr_ptr_r[w] <= wr_ptr_r[w] + PW'(1);
          if (pop_s[w])  rd_ptr_r[w] <= rd_ptr_r[w] + PW'(1);
          case ({push_s[w], pop_s[w]})
            2'b10:   cnt_r[w] <= cnt_r[w] + CW'(1);
            2'b01:   cnt_r[w] <= cnt_r[w] - CW'(1);
            default: cnt_r[w] <= cnt_r[w];
          endcase
        end
      end
    end
  end

  // Output register and round-robin pointer; output entry survives a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r    <= WIS_W'(0);
      out_valid_r <= 1'b0;
      out_wis_r   <= WIS_W'(0);
      out_data_r  <= DATAW'(0);
    end else begin
      if (grant_s) rr_ptr_r <= gidx_s + WIS_W'(1);
      if (load_en_s) begin
        out_valid_r <= grant_s;
        if (grant_s) begin
          out_wis_r  <= gidx_s;
          out_data_r <= head_s;
        end
      end
    end
  end

  // Flatten registered occupancy into the exported bus
  always_comb begin
    wcount = {(ISSUE_WARPS*CW){1'b0}};
    for (int w = 0; w < ISSUE_WARPS; w++) begin
      wcount[w*CW +: CW] = cnt_r[w];
    end
  end

  assign out_if.valid = out_valid_r;
  assign out_if.wis   = out_wis_r;
  assign out_if.data  = out_data_r;

  uop_ibuffer_checker #(
    .ISSUE_WARPS(ISSUE_WARPS),
    .DEPTH      (DEPTH),
    .DATAW      (DATAW),
    .CW         (CW)
  ) u_checker (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .pop      (pop_s),
    .wcount   (wcount),
    .out_valid(out_valid_r),
    .out_ready(out_if.ready),
    .out_data (out_data_r)
  );
endmodule

// File: tb/tb_uop_ibuffer.sv
// Directed bench for uop_ibuffer: stimulus pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares every accepted output.
module tb_uop_ibuffer;
  localparam int ISSUE_WARPS = 4;
  localparam int DEPTH       = 4;
  localparam int DATAW       = 128;
  localparam int WIS_W       = 2;
  localparam int CW          = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      flush_valid;
  logic [WIS_W-1:0]          flush_wis;
  logic [ISSUE_WARPS-1:0]    stall_mask;
  logic [ISSUE_WARPS*CW-1:0] wcount;

  int checks = 0;
  int errors = 0;
  logic [WIS_W+DATAW-1:0] exp_q[$];

  uop_ibuffer_if #(.WIS_W(WIS_W), .DATAW(DATAW)) in_if ();
  uop_ibuffer_if #(.WIS_W(WIS_W), .DATAW(DATAW)) out_if ();

  uop_ibuffer #(
    .ISSUE_WARPS(ISSUE_WARPS), .DEPTH(DEPTH), .DATAW(DATAW), .WIS_W(WIS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (in_if),
    .out_if     (out_if),
    .flush_valid(flush_valid),
    .flush_wis  (flush_wis),
    .stall_mask (stall_mask),
    .wcount     (wcount)
  );

  always #5 clk = ~clk;

  function automatic logic [DATAW-1:0] dv(input int w, input int k);
    return {4{8'(w), 8'(k), 16'hBEEF}};
  endfunction

  function automatic logic [CW-1:0] wc(input int w);
    return wcount[w*CW +: CW];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_push(input int w, input int k);
    in_if.valid = 1'b1;
    in_if.wis   = WIS_W'(w);
    in_if.data  = dv(w, k);
  endtask

  task automatic expect_out(input int w, input int k);
    exp_q.push_back({WIS_W'(w), dv(w, k)});
  endtask

  task automatic idle_in();
    in_if.valid = 1'b0;
    in_if.wis   = WIS_W'(0);
    in_if.data  = DATAW'(0);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain_timeout pending=%0d required=0", name, exp_q.size());
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [WIS_W+DATAW-1:0] got;
    logic [WIS_W+DATAW-1:0] exp;
    if (!reset && out_if.valid && out_if.ready) begin
      got = {out_if.wis, out_if.data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected actual=%0h required=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL out_order actual=%0h required=%0h", got, exp);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    flush_valid  = 1'b0;
    flush_wis    = WIS_W'(0);
    stall_mask   = 4'b0000;
    out_if.ready = 1'b1;
    idle_in();
    cyc();
    cyc();
    chk("reset_out_valid", DATAW'(out_if.valid), DATAW'(0));
    chk("reset_wcount", DATAW'(wcount), DATAW'(0));
    reset = 1'b0;

    // Single push to warp 2: visible at T+1, output at T+2
    drive_push(2, 0);
    expect_out(2, 0);
    chk("t1_in_ready", DATAW'(in_if.ready), DATAW'(1));
    cyc();
    idle_in();
    chk("t1_wcount2_t1", DATAW'(wc(2)), DATAW'(1));
    chk("t1_out_valid_t1", DATAW'(out_if.valid), DATAW'(0));
    cyc();
    chk("t1_out_valid_t2", DATAW'(out_if.valid), DATAW'(1));
    chk("t1_wcount2_t2", DATAW'(wc(2)), DATAW'(0));
    drain("t1", 4);

    // Fill warp 0: one entry parks in the output register, four in the FIFO
    out_if.ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_push(0, k);
      expect_out(0, k);
      cyc();
    end
    idle_in();
    chk("t2_wcount0_full", DATAW'(wc(0)), DATAW'(4));
    in_if.wis = WIS_W'(0);
    #1;
    chk("t2_in_ready_w0", DATAW'(in_if.ready), DATAW'(0));
    in_if.wis = WIS_W'(1);
    #1;
    chk("t2_in_ready_w1", DATAW'(in_if.ready), DATAW'(1));
    out_if.ready = 1'b1;
    drain("t2", 20);
    cyc();
    chk("t2_wcount0_empty", DATAW'(wc(0)), DATAW'(0));

    // Flush warp 1 with a concurrent push; parked output entry still delivered
    out_if.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_push(1, k);
      cyc();
    end
    expect_out(1, 0);
    idle_in();
    chk("t5_wcount1_pre", DATAW'(wc(1)), DATAW'(3));
    flush_valid = 1'b1;
    flush_wis   = WIS_W'(1);
    drive_push(1, 9);
    #1;
    chk("t5_flush_in_ready", DATAW'(in_if.ready), DATAW'(0));
    cyc();
    flush_valid = 1'b0;
    idle_in();
    chk("t5_wcount1_post", DATAW'(wc(1)), DATAW'(0));
    chk("t5_out_kept_valid", DATAW'(out_if.valid), DATAW'(1));
    chk("t5_out_kept_wis", DATAW'(out_if.wis), DATAW'(1));
    out_if.ready = 1'b1;
    drain("t5", 4);
    cyc();
    cyc();
    chk("t5_no_more_out", DATAW'(out_if.valid), DATAW'(0));

    // Reset with entries in every warp and a parked output
    out_if.ready = 1'b0;
    drive_push(0, 0); cyc();
    drive_push(1, 0); cyc();
    drive_push(2, 0); cyc();
    drive_push(3, 0); cyc();
    drive_push(0, 1); cyc();
    idle_in();
    chk("t6_pre_out_valid", DATAW'(out_if.valid), DATAW'(1));
    chk("t6_pre_wcount3", DATAW'(wc(3)), DATAW'(1));
    reset = 1'b1;
    exp_q.delete();
    cyc();
    reset = 1'b0;
    chk("t6_out_valid", DATAW'(out_if.valid), DATAW'(0));
    chk("t6_wcount", DATAW'(wcount), DATAW'(0));

    // Preload 2 per warp under full stall, then release: 0,1,2,3,0,1,2,3
    out_if.ready = 1'b1;
    stall_mask   = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 4; w++) begin
        drive_push(w, k);
        expect_out(w, k);
        cyc();
      end
    end
    idle_in();
    stall_mask = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t3_no_bubble", DATAW'(out_if.valid), DATAW'(1));
    end
    cyc();
    chk("t3_idle_after", DATAW'(out_if.valid), DATAW'(0));

    // Same preload with warp 1 stalled: 0,2,3,0,2,3 then 1,1
    stall_mask = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 4; w++) begin
        drive_push(w, k);
        cyc();
      end
    end
    idle_in();
    expect_out(0, 0); expect_out(2, 0); expect_out(3, 0);
    expect_out(0, 1); expect_out(2, 1); expect_out(3, 1);
    expect_out(1, 0); expect_out(1, 1);
    stall_mask = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      cyc();
    end
    cyc();
    chk("t4_stalled_gap", DATAW'(out_if.valid), DATAW'(0));
    chk("t4_wcount1_held", DATAW'(wc(1)), DATAW'(2));
    stall_mask = 4'b0000;
    drain("t4", 10);
    cyc();
    cyc();
    chk("t4_final_wcount", DATAW'(wcount), DATAW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uop_ibuffer.md
# uop_ibuffer

Per-warp instruction buffer that sits directly downstream of the tensor micro-op sequencer. It accepts one decoded or micro-op-expanded instruction per cycle and queues it in a FIFO selected by its issue-warp index. A round-robin arbiter then picks one eligible warp head per cycle. The chosen instruction is driven through a registered output stage to the scheduler/scoreboard. Per-warp occupancy is exported so the warp scheduler can throttle fetch.

## Interface
Parameters:
- ISSUE_WARPS, 4: warps per issue slice; power of 2, ≥2.
- DEPTH, 4: entries per warp FIFO; power of 2, ≥2.
- DATAW, 128: width of the instruction payload (uuid, tmask, PC, ex/op type, mods, wb, rd/rs1/rs2/rs3, imm, packed).
- WIS_W, $clog2(ISSUE_WARPS): warp index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  an instruction is offered.
- in_wis  in  WIS_W  destination warp of the offered instruction.
- in_data  in  DATAW  instruction payload.
- in_ready  out  1  instruction accepted this cycle.
- flush_valid  in  1  discard all queued entries of one warp.
- flush_wis  in  WIS_W  warp to flush.
- stall_mask  in  ISSUE_WARPS  bit w=1 makes warp w ineligible for arbitration (scoreboard/barrier stall).
- out_valid  out  1  registered output holds an instruction.
- out_wis  out  WIS_W  warp of the output instruction.
- out_data  out  DATAW  output payload.
- out_ready  in  1  consumer takes the output.
- wcount  out  ISSUE_WARPS*($clog2(DEPTH)+1)  per-warp FIFO occupancy. Warp w occupies bits [w*(CW)+:CW], with CW=$clog2(DEPTH)+1.

## Operation
- Per-warp FIFO: rd_ptr and wr_ptr each $clog2(DEPTH) bits and wrap mod DEPTH; count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Push: in_fire = in_valid && in_ready. in_ready = (count[in_wis] < DEPTH) && !(flush_valid && flush_wis == in_wis).
  - in_ready must not depend on a same-cycle pop; there is no pass-through when full.
- Eligibility: warp w is eligible when count[w] != 0 and !stall_mask[w] and !(flush_valid && flush_wis == w).
- Arbiter:
  - Runs only when the output stage can load: load_en = !out_valid || out_ready.
  - Priority order starts at rr_ptr and wraps.
  - On a grant to warp g, the head entry is popped, loaded into the output register, and rr_ptr <= (g+1) mod ISSUE_WARPS.
  - With no eligible warp: rr_ptr is unchanged; out_valid <= 0 if load_en.
- Output stage:
  - One register (valid, wis, data) holds its contents stable while out_valid && !out_ready.
  - When both out_valid && out_ready and a grant occur, it reloads back-to-back, giving 1 instruction per cycle.
- Flush: the selected warp's count <= 0 and rd_ptr <= wr_ptr. A concurrent push to that warp is refused (in_ready=0). An entry of that warp already in the output register is NOT cancelled.
- Simultaneous push and pop on the same warp: count unchanged and both pointers advance. Legal only when count ≥1 before the cycle.
- Reset:
  - all counts and pointers 0, rr_ptr 0, out_valid 0.
  - out_wis/out_data are don't-care but are driven to 0.
  - wcount reads all zero in the cycle after reset is asserted.
  - Reset mid-operation drops every queued and output entry; no partial state survives.

## Timing
- Min latency: push at cycle T, head visible to the arbiter at T+1, out_valid=1 at T+2. There is no same-cycle write-to-read bypass.
- Throughput: 1 push and 1 output per cycle, sustained across different or same warps.
- stall_mask and flush are sampled combinationally in the arbitration cycle. Their effect on out_valid appears one cycle later.
- wcount is registered and reflects pushes/pops/flushes of cycle T at T+1.
- Assertions:
  - no push when count==DEPTH.
  - no pop when count==0.
  - out_data stable while out_valid && !out_ready.

## Test plan
- Single push warp 2 at T, out_ready=1 -> out_valid=1, out_wis=2, out_data matches at T+2. wcount[2] goes 1 at T+1 and 0 at T+2.
- Fill warp 0 with 4 entries, keep out_ready=0 -> in_ready=0 for in_wis=0 and 1 for in_wis=1. Entries leave in FIFO order once out_ready=1.
- Preload warps 0..3 with 2 entries each, out_ready=1 constantly -> grant order 0,1,2,3,0,1,2,3 on consecutive cycles with no bubbles.
- Same preload, stall_mask=4'b0010 -> order 0,2,3,0,2,3. Clearing the mask then yields warp 1's two entries.
- Warp 1 holds 3 entries, one in the output register, out_ready=0; pulse flush_wis=1 together with a push to warp 1 -> push refused and wcount[1]=0 next cycle. The output entry persists and is delivered when out_ready=1.
- Assert reset for 1 cycle with entries in all warps and out_valid=1 -> next cycle out_valid=0, all wcount 0, and the next grant starts at warp 0.
